wb_commit_stage: RTL
====================

// Module: wb_commit_stage
// PURPOSE
//  Registered write-back/commit stage; parametrised successor of the combinational WB mux.
//  Sits between MEM/WB and the register file / HI-LO unit and captures one instruction per cycle.
//  Stall/flush are driven by the hazard unit. Selects the ALU, memory or exception result.
//  Optionally aligns and extends sub-word loads, then drives RF, HI/LO and forwarding writes.
//  Counts committed instructions.
// PARAMETERS
//  WIDTH      32  datapath width; load alignment requires WIDTH=32
//  RF_ADDR_W  7   RF address width (GPR plus CP0 space)
//  CNT_W      32  width of the commit counter
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          asynchronous reset, active-high
//  stall          in   1          hold the stage register
//  flush          in   1          squash the entry being captured
//  in_valid       in   1          MEM stage holds a real instruction
//  aluout         in   WIDTH      ALU result
//  Memdata        in   WIDTH      raw load word from data memory
//  mem_addr_lo    in   2          load address bits [1:0]
//  load_type      in   3          0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
//  MemtoRegW      in   1          1 selects aluout, 0 selects the memory result
//  rf_we_in       in   1          instruction writes the RF
//  rf_addr_in     in   RF_ADDR_W  destination register
//  exc_addr_sel   in   1          override the destination with exc_addr
//  exc_addr       in   RF_ADDR_W  exception destination register
//  exc_data_sel   in   1          override the data with exc_data
//  exc_data       in   WIDTH      exception write data
//  hilo_we_in     in   1          instruction writes HI/LO
//  hi_in, lo_in   in   WIDTH      HI and LO results
//  rf_we          out  1          RF write enable
//  rf_waddr       out  RF_ADDR_W  RF write address
//  rf_wdata       out  WIDTH      RF write data, also the forwarding source
//  hilo_we        out  1          HI/LO write enable
//  hilo_wdata     out  2*WIDTH    {HI, LO}
//  commit_cnt     out  CNT_W      count of committed instructions
// BEHAVIOUR
//  - Stage register update at each posedge, by priority:
//    - rst: async clear of all state.
//    - flush: valid_q <= 0; the other fields are don't-care.
//    - stall (no flush): hold all fields.
//    - otherwise: capture all inputs and set valid_q <= in_valid.
//    - flush wins over stall when both are asserted.
//  - Latency: exactly 1 cycle from the input edge to the outputs.
//  - Outputs are combinational decode of the register only; no input-to-output path.
//  - Result mux: res = MemtoRegW ? aluout : ld_res.
//  - Data select: rf_wdata = exc_data_sel ? exc_data : res.
//  - Address select: rf_waddr = exc_addr_sel ? exc_addr : rf_addr_in.
//  - rf_we = valid_q & (rf_we_in | exc_data_sel) & (rf_waddr != 0).
//    - Writes to r0 are suppressed, including exception writes.
//  - hilo_we = valid_q & hilo_we_in; hilo_wdata = {hi_in, lo_in}.
//  - While stalled, the outputs repeat the held write; re-writing the same value is idempotent.
//  - commit_cnt increments by 1 on each edge where the register loads with in_valid=1.
//    - No increment on stall, flush or bubble cycles.
//    - Wraps modulo 2^CNT_W.
//  - Reset values: valid_q=0, so rf_we=0 and hilo_we=0.
//    - rf_waddr=0, rf_wdata=0, hilo_wdata=0, commit_cnt=0.
//  - Reset asserted mid-stall clears everything; the held instruction is lost.
//  - load_type 5..7 is treated as LW.
// CONFIGURATION
//  - WB_LOAD_ALIGN_EN defined: ld_res is aligned and extended.
//    - LB/LBU take byte mem_addr_lo, i.e. Memdata[8*lo+7:8*lo], sign- or zero-extended.
//    - LH/LHU take Memdata[16*a1+15:16*a1] with a1 = mem_addr_lo[1], sign- or zero-extended.
//    - LW passes Memdata unchanged.
//  - WB_LOAD_ALIGN_EN undefined: ld_res = Memdata; load_type and mem_addr_lo are ignored.
//    - Alignment is then done upstream.
// TESTING
//  - Reset: rst=1 mid-run -> all outputs 0 immediately and commit_cnt=0; the cycle after release still shows rf_we=0.
//  - ALU path: in_valid=1, MemtoRegW=1, aluout=0x1234, rf_addr_in=5, rf_we_in=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, commit_cnt+1.
//  - Sign-extended byte load (ALIGN_EN): MemtoRegW=0, Memdata=0x80FF7F01, lo=3, LB -> rf_wdata=0xFFFFFF80.
//    - Same word, LHU, lo=2 -> rf_wdata=0x000080FF.
//  - Hazards: stall=1 for 3 cycles -> outputs held and commit_cnt unchanged.
//    - stall=1 & flush=1 -> next cycle rf_we=0, hilo_we=0, no count.
//  - Exception override: exc_addr_sel=1, exc_addr=0x48, exc_data_sel=1, exc_data=0xBFC00380 -> rf_waddr=0x48, rf_wdata=0xBFC00380.
//    - exc_addr=0 -> rf_we=0.
//  - HI/LO and r0: hilo_we_in=1, hi=0xA, lo=0xB -> hilo_wdata=0x0000000A_0000000B.
//    - rf_we_in=1, rf_addr_in=0 -> rf_we=0.

Source files
------------

// File: rtl/wb_commit_stage.sv
// Registered write-back/commit stage: result select, optional sub-word load alignment, RF/HI-LO write drive and commit counter.
// Optional feature: define WB_LOAD_ALIGN_EN to align and extend sub-word loads in this stage (requires WIDTH=32).
module wb_commit_stage #(
   parameter int WIDTH     = 32,
   parameter int RF_ADDR_W = 7,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     aluout,
   input  logic [WIDTH-1:0]     Memdata,
   input  logic [1:0]           mem_addr_lo,
   input  logic [2:0]           load_type,
   input  logic                 MemtoRegW,
   input  logic                 rf_we_in,
   input  logic [RF_ADDR_W-1:0] rf_addr_in,
   input  logic                 exc_addr_sel,
   input  logic [RF_ADDR_W-1:0] exc_addr,
   input  logic                 exc_data_sel,
   input  logic [WIDTH-1:0]     exc_data,
   input  logic                 hilo_we_in,
   input  logic [WIDTH-1:0]     hi_in,
   input  logic [WIDTH-1:0]     lo_in,
   output logic                 rf_we,
   output logic [RF_ADDR_W-1:0] rf_waddr,
   output logic [WIDTH-1:0]     rf_wdata,
   output logic                 hilo_we,
   output logic [2*WIDTH-1:0]   hilo_wdata,
   output logic [CNT_W-1:0]     commit_cnt
);

   localparam logic [2:0] LT_LB  = 3'd1;
   localparam logic [2:0] LT_LBU = 3'd2;
   localparam logic [2:0] LT_LH  = 3'd3;
   localparam logic [2:0] LT_LHU = 3'd4;

   logic                 vld_p1;
   logic [WIDTH-1:0]     aluout_p1;
   logic [WIDTH-1:0]     memdata_p1;
   logic                 memtoreg_p1;
   logic                 rf_we_in_p1;
   logic [RF_ADDR_W-1:0] rf_addr_p1;
   logic                 exc_addr_sel_p1;
   logic [RF_ADDR_W-1:0] exc_addr_p1;
   logic                 exc_data_sel_p1;
   logic [WIDTH-1:0]     exc_data_p1;
   logic                 hilo_we_in_p1;
   logic [WIDTH-1:0]     hi_p1;
   logic [WIDTH-1:0]     lo_p1;
   logic [CNT_W-1:0]     cnt_p1;
   logic [WIDTH-1:0]     ld_res;
   logic [WIDTH-1:0]     res;
   logic                 load_en;

   assign load_en = ~flush & ~stall;

`ifdef WB_LOAD_ALIGN_EN
   logic [1:0] addr_lo_p1;
   logic [2:0] load_type_p1;

   // Codes 5..7 fall through to the full-word case.
   function automatic logic [WIDTH-1:0] ld_align(input logic [WIDTH-1:0] w,
                                                 input logic [1:0]       a,
                                                 input logic [2:0]       t);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [WIDTH-1:0]   r;
      b = w[8*a +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (t)
         LT_LB:   r = WIDTH'(b);
         LT_LBU:  r = {{(WIDTH-8){1'b0}}, b};
         LT_LH:   r = WIDTH'(h);
         LT_LHU:  r = {{(WIDTH-16){1'b0}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_lo_p1   <= '0;
         load_type_p1 <= '0;
      end else if (load_en) begin
         addr_lo_p1   <= mem_addr_lo;
         load_type_p1 <= load_type;
      end
   end

   assign ld_res = ld_align(memdata_p1, addr_lo_p1, load_type_p1);
`else
   logic unused_ld_ctrl;
   assign unused_ld_ctrl = ^{mem_addr_lo, load_type, LT_LB, LT_LBU, LT_LH, LT_LHU};
   assign ld_res = memdata_p1;
`endif

   // Stage boundary p0 -> p1: flush drops only the valid bit, stall holds everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1          <= 1'b0;
         aluout_p1       <= '0;
         memdata_p1      <= '0;
         memtoreg_p1     <= 1'b0;
         rf_we_in_p1     <= 1'b0;
         rf_addr_p1      <= '0;
         exc_addr_sel_p1 <= 1'b0;
         exc_addr_p1     <= '0;
         exc_data_sel_p1 <= 1'b0;
         exc_data_p1     <= '0;
         hilo_we_in_p1   <= 1'b0;
         hi_p1           <= '0;
         lo_p1           <= '0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (!stall) begin
         vld_p1          <= in_valid;
         aluout_p1       <= aluout;
         memdata_p1      <= Memdata;
         memtoreg_p1     <= MemtoRegW;
         rf_we_in_p1     <= rf_we_in;
         rf_addr_p1      <= rf_addr_in;
         exc_addr_sel_p1 <= exc_addr_sel;
         exc_addr_p1     <= exc_addr;
         exc_data_sel_p1 <= exc_data_sel;
         exc_data_p1     <= exc_data;
         hilo_we_in_p1   <= hilo_we_in;
         hi_p1           <= hi_in;
         lo_p1           <= lo_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_p1 <= '0;
      else if (load_en && in_valid)
         cnt_p1 <= cnt_p1 + 1'b1;
   end

   // Output decode from p1 only; r0 writes are dropped even on the exception path.
   assign res        = memtoreg_p1 ? aluout_p1 : ld_res;
   assign rf_wdata   = exc_data_sel_p1 ? exc_data_p1 : res;
   assign rf_waddr   = exc_addr_sel_p1 ? exc_addr_p1 : rf_addr_p1;
   assign rf_we      = vld_p1 & (rf_we_in_p1 | exc_data_sel_p1) & (rf_waddr != '0);
   assign hilo_we    = vld_p1 & hilo_we_in_p1;
   assign hilo_wdata = {hi_p1, lo_p1};
   assign commit_cnt = cnt_p1;

endmodule
